// File: rtl/bure_stage_id_hs_pkg.sv
// Shared RV32/RV64 instruction field extraction, opcode set and decode-stage types.
// Imported by the decode stage and its valid/ready pipe register.
package bure_stage_id_hs_pkg;

  localparam logic [6:0] OpLoad    = 7'h03;
  localparam logic [6:0] OpMiscMem = 7'h0F;
  localparam logic [6:0] OpImm     = 7'h13;
  localparam logic [6:0] OpAuipc   = 7'h17;
  localparam logic [6:0] OpImm32   = 7'h1B;
  localparam logic [6:0] OpStore   = 7'h23;
  localparam logic [6:0] OpReg     = 7'h33;
  localparam logic [6:0] OpLui     = 7'h37;
  localparam logic [6:0] OpReg32   = 7'h3B;
  localparam logic [6:0] OpBranch  = 7'h63;
  localparam logic [6:0] OpJalr    = 7'h67;
  localparam logic [6:0] OpJal     = 7'h6F;
  localparam logic [6:0] OpSystem  = 7'h73;

  typedef enum logic [1:0] {StEmpty, StFull, StSkid} skid_state_e;

  typedef struct packed {
    logic is_imm_op;
    logic is_jump_op;
    logic is_branch_op;
    logic is_load_op;
    logic is_store_op;
  } id_flags_t;

  typedef struct packed {
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rd_wen;
    id_flags_t  flags;
    logic       illegal;
  } id_fields_t;

  function automatic logic [6:0] get_opcode(logic [31:0] instr);
    return instr[6:0];
  endfunction

  function automatic logic [4:0] get_rd(logic [31:0] instr);
    return instr[11:7];
  endfunction

  function automatic logic [4:0] get_rs1(logic [31:0] instr);
    return instr[19:15];
  endfunction

  function automatic logic [4:0] get_rs2(logic [31:0] instr);
    return instr[24:20];
  endfunction

  function automatic logic [2:0] get_funct3(logic [31:0] instr);
    return instr[14:12];
  endfunction

  function automatic logic [6:0] get_funct7(logic [31:0] instr);
    return instr[31:25];
  endfunction

  function automatic logic is_legal_opcode(logic [31:0] instr);
    if (instr[1:0] != 2'b11) return 1'b0;
    case (instr[6:0])
      OpLoad, OpMiscMem, OpImm, OpAuipc, OpImm32, OpStore, OpReg, OpLui, OpReg32,
      OpBranch, OpJalr, OpJal, OpSystem: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // 32-bit signed immediate; callers sign-extend to their XLEN.
  function automatic logic [31:0] get_imm(logic [31:0] instr);
    case (instr[6:0])
      OpLoad, OpMiscMem, OpImm, OpImm32, OpJalr, OpSystem:
        return {{20{instr[31]}}, instr[31:20]};
      OpStore:
        return {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OpBranch:
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OpLui, OpAuipc:
        return {instr[31:12], 12'b0};
      OpJal:
        return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:
        return '0;
    endcase
  endfunction

endpackage

// File: rtl/bure_stage_id_hs_if.sv
// Fetch-side offer and execute-side decoded bundle of the decode stage.
// slave is the stage's view, master the surrounding pipeline's view.
interface bure_stage_id_hs_if #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH  = 32
);
  logic                   i_instr_valid;
  logic                   o_instr_ready;
  logic [INSTR_WIDTH-1:0] i_instr;
  logic [ADDR_WIDTH-1:0]  i_pc;
  logic                   o_decode_valid;
  logic                   i_decode_ready;
  logic [ADDR_WIDTH-1:0]  o_pc;
  logic [2:0]             o_funct3;
  logic [6:0]             o_funct7;
  logic [4:0]             o_rs1_addr;
  logic [4:0]             o_rs2_addr;
  logic [4:0]             o_rd_addr;
  logic                   o_rd_wen;
  logic [DATA_WIDTH-1:0]  o_imm;
  logic                   o_is_imm_op;
  logic                   o_is_jump_op;
  logic                   o_is_branch_op;
  logic                   o_is_load_op;
  logic                   o_is_store_op;
  logic                   o_illegal;

  modport slave (
    input  i_instr_valid, i_instr, i_pc, i_decode_ready,
    output o_instr_ready, o_decode_valid, o_pc, o_funct3, o_funct7, o_rs1_addr, o_rs2_addr,
           o_rd_addr, o_rd_wen, o_imm, o_is_imm_op, o_is_jump_op, o_is_branch_op,
           o_is_load_op, o_is_store_op, o_illegal
  );

  modport master (
    output i_instr_valid, i_instr, i_pc, i_decode_ready,
    input  o_instr_ready, o_decode_valid, o_pc, o_funct3, o_funct7, o_rs1_addr, o_rs2_addr,
           o_rd_addr, o_rd_wen, o_imm, o_is_imm_op, o_is_jump_op, o_is_branch_op,
           o_is_load_op, o_is_store_op, o_illegal
  );
endinterface

// File: rtl/bure_pipe_skid.sv
// Generic valid/ready pipeline register with an optional one-entry skid buffer.
// With SkidEn the upstream ready is registered, breaking the ready timing path.
module bure_pipe_skid
  import bure_stage_id_hs_pkg::*;
#(
  parameter int unsigned Width  = 8,
  parameter bit          SkidEn = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o
);

  skid_state_e      state_q, state_d;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;
  logic [Width-1:0] out_q, out_d;
  logic [Width-1:0] skid_q, skid_d;
  logic             accept, consume;

  assign in_ready_o  = SkidEn ? ready_q : (!valid_q || out_ready_i);
  assign accept      = in_valid_i && in_ready_o && !flush_i;
  assign consume     = valid_q && out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = out_q;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d = StFull;
          out_d   = in_data_i;
        end
      end
      StFull: begin
        // Without a skid entry an accept while full always coincides with a consume.
        if (accept && consume) begin
          out_d = in_data_i;
        end else if (accept) begin
          state_d = StSkid;
          skid_d  = in_data_i;
        end else if (consume) begin
          state_d = StEmpty;
        end
      end
      StSkid: begin
        if (consume) begin
          state_d = StFull;
          out_d   = skid_q;
        end
      end
      default: state_d = StEmpty;
    endcase
    if (flush_i) state_d = StEmpty;
    valid_d = (state_d != StEmpty);
    ready_d = (state_d != StSkid);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StEmpty;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/bure_stage_id_hs.sv
// RV32/RV64 instruction-decode stage: combinational decode of the fetch offer,
// packed into a valid/ready pipe register towards execute, with flush.
module bure_stage_id_hs
  import bure_stage_id_hs_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter bit          SKID_EN     = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_flush,
  bure_stage_id_hs_if.slave bus
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] imm;
    id_fields_t            f;
  } id_bundle_t;

  logic [INSTR_WIDTH-1:0] instr_raw;
  logic [31:0]            instr;
  logic [6:0]             opcode;
  logic [31:0]            imm32;
  id_fields_t             fields;
  id_bundle_t             dec_bundle;
  id_bundle_t             out_bundle;

  assign instr_raw = bus.i_instr;
  assign instr     = instr_raw[31:0];
  assign opcode    = get_opcode(instr);

  always_comb begin
    fields         = '0;
    fields.funct3  = get_funct3(instr);
    fields.funct7  = get_funct7(instr);
    fields.rs1     = get_rs1(instr);
    fields.rs2     = get_rs2(instr);
    fields.rd      = get_rd(instr);
    fields.illegal = !is_legal_opcode(instr);
    imm32          = '0;
    // Illegal words travel as inert bundles: no writeback, no class, zero immediate.
    if (!fields.illegal) begin
      fields.flags.is_imm_op    = opcode inside {OpImm, OpImm32};
      fields.flags.is_jump_op   = opcode inside {OpJal, OpJalr};
      fields.flags.is_branch_op = (opcode == OpBranch);
      fields.flags.is_load_op   = (opcode == OpLoad);
      fields.flags.is_store_op  = (opcode == OpStore);
      fields.rd_wen = !(opcode inside {OpStore, OpBranch, OpMiscMem}) && (fields.rd != 5'd0);
      imm32         = get_imm(instr);
    end
  end

  always_comb begin
    dec_bundle     = '0;
    dec_bundle.pc  = bus.i_pc;
    dec_bundle.imm = DATA_WIDTH'($signed(imm32));
    dec_bundle.f   = fields;
  end

  bure_pipe_skid #(
    .Width  ($bits(id_bundle_t)),
    .SkidEn (SKID_EN)
  ) u_pipe (
    .clk_i       (i_clk),
    .rst_ni      (i_rstn),
    .flush_i     (i_flush),
    .in_valid_i  (bus.i_instr_valid),
    .in_ready_o  (bus.o_instr_ready),
    .in_data_i   (dec_bundle),
    .out_valid_o (bus.o_decode_valid),
    .out_ready_i (bus.i_decode_ready),
    .out_data_o  (out_bundle)
  );

  assign bus.o_pc           = out_bundle.pc;
  assign bus.o_imm          = out_bundle.imm;
  assign bus.o_funct3       = out_bundle.f.funct3;
  assign bus.o_funct7       = out_bundle.f.funct7;
  assign bus.o_rs1_addr     = out_bundle.f.rs1;
  assign bus.o_rs2_addr     = out_bundle.f.rs2;
  assign bus.o_rd_addr      = out_bundle.f.rd;
  assign bus.o_rd_wen       = out_bundle.f.rd_wen;
  assign bus.o_is_imm_op    = out_bundle.f.flags.is_imm_op;
  assign bus.o_is_jump_op   = out_bundle.f.flags.is_jump_op;
  assign bus.o_is_branch_op = out_bundle.f.flags.is_branch_op;
  assign bus.o_is_load_op   = out_bundle.f.flags.is_load_op;
  assign bus.o_is_store_op  = out_bundle.f.flags.is_store_op;
  assign bus.o_illegal      = out_bundle.f.illegal;

endmodule

// File: tb/tb_bure_stage_id_hs.sv
// Scoreboard bench for the decode stage: one instance with skid, one without,
// sharing stimulus; each has its own occupancy model and expected-bundle queue.
module tb_bure_stage_id_hs;

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        wen;
    logic [63:0] imm;
    logic [4:0]  fl;  // {imm, jump, branch, load, store}
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        flush = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr_w = '0;
  logic [31:0] pc_w = '0;
  logic        dec_ready = 1'b0;
  int          cur_idx = 0;
  bit          last_acc1;
  int          checks = 0;
  int          failures = 0;
  exp_t        q1[$];
  exp_t        q0[$];

  always #5 clk = ~clk;

  bure_stage_id_hs_if #(.DATA_WIDTH(64), .INSTR_WIDTH(32), .ADDR_WIDTH(32)) bus1 ();
  bure_stage_id_hs_if #(.DATA_WIDTH(64), .INSTR_WIDTH(32), .ADDR_WIDTH(32)) bus0 ();

  assign bus1.i_instr_valid  = instr_valid;
  assign bus1.i_instr        = instr_w;
  assign bus1.i_pc           = pc_w;
  assign bus1.i_decode_ready = dec_ready;
  assign bus0.i_instr_valid  = instr_valid;
  assign bus0.i_instr        = instr_w;
  assign bus0.i_pc           = pc_w;
  assign bus0.i_decode_ready = dec_ready;

  bure_stage_id_hs #(
    .DATA_WIDTH(64), .INSTR_WIDTH(32), .ADDR_WIDTH(32), .SKID_EN(1'b1)
  ) dut1 (
    .i_clk(clk), .i_rstn(rstn), .i_flush(flush), .bus(bus1.slave)
  );

  bure_stage_id_hs #(
    .DATA_WIDTH(64), .INSTR_WIDTH(32), .ADDR_WIDTH(32), .SKID_EN(1'b0)
  ) dut0 (
    .i_clk(clk), .i_rstn(rstn), .i_flush(flush), .bus(bus0.slave)
  );

  logic [127:0] bnd1, bnd0;
  assign bnd1 = {bus1.o_pc, bus1.o_funct3, bus1.o_funct7, bus1.o_rs1_addr, bus1.o_rs2_addr,
                 bus1.o_rd_addr, bus1.o_rd_wen, bus1.o_imm, bus1.o_is_imm_op, bus1.o_is_jump_op,
                 bus1.o_is_branch_op, bus1.o_is_load_op, bus1.o_is_store_op, bus1.o_illegal};
  assign bnd0 = {bus0.o_pc, bus0.o_funct3, bus0.o_funct7, bus0.o_rs1_addr, bus0.o_rs2_addr,
                 bus0.o_rd_addr, bus0.o_rd_wen, bus0.o_imm, bus0.o_is_imm_op, bus0.o_is_jump_op,
                 bus0.o_is_branch_op, bus0.o_is_load_op, bus0.o_is_store_op, bus0.o_illegal};

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] instr_of(input int i);
    case (i)
      0:       return 32'h0051_0093;  // addi x1,x2,5
      1:       return 32'hFE51_2E23;  // sw x5,-4(x2)
      2:       return 32'h0000_0000;
      3:       return 32'h0000_0013;  // addi x0,x0,0
      4:       return 32'h0080_00EF;  // jal x1,8
      5:       return 32'hFE20_8CE3;  // beq x1,x2,-8
      6:       return 32'h0102_2183;  // lw x3,16(x4)
      7:       return 32'h0073_02B3;  // add x5,x6,x7
      8:       return 32'h1234_5537;  // lui x10,0x12345
      9:       return 32'h0051_0090;  // addi with instr[1:0]=00
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic exp_t mk(input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [4:0] rd, input logic wen,
                              input logic [63:0] imm, input logic [4:0] fl, input logic ill);
    exp_t e;
    e = '{pc: 32'h0, f3: f3, f7: f7, rs1: rs1, rs2: rs2, rd: rd, wen: wen, imm: imm, fl: fl,
          ill: ill};
    return e;
  endfunction

  function automatic exp_t tbl(input int i);
    case (i)
      0:       return mk(3'd0, 7'h00, 5'd2, 5'd5, 5'd1, 1'b1, 64'd5, 5'b10000, 1'b0);
      1:       return mk(3'd2, 7'h7F, 5'd2, 5'd5, 5'd28, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC,
                         5'b00001, 1'b0);
      2:       return mk(3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 1'b0, 64'd0, 5'b00000, 1'b1);
      3:       return mk(3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 1'b0, 64'd0, 5'b10000, 1'b0);
      4:       return mk(3'd0, 7'h00, 5'd0, 5'd8, 5'd1, 1'b1, 64'd8, 5'b01000, 1'b0);
      5:       return mk(3'd0, 7'h7F, 5'd1, 5'd2, 5'd25, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8,
                         5'b00100, 1'b0);
      6:       return mk(3'd2, 7'h00, 5'd4, 5'd16, 5'd3, 1'b1, 64'd16, 5'b00010, 1'b0);
      7:       return mk(3'd0, 7'h00, 5'd6, 5'd7, 5'd5, 1'b1, 64'd0, 5'b00000, 1'b0);
      8:       return mk(3'd5, 7'h09, 5'd8, 5'd3, 5'd10, 1'b1, 64'h1234_5000, 5'b00000, 1'b0);
      9:       return mk(3'd0, 7'h00, 5'd2, 5'd5, 5'd1, 1'b0, 64'd0, 5'b00000, 1'b1);
      default: return mk(3'd7, 7'h7F, 5'd31, 5'd31, 5'd31, 1'b0, 64'd0, 5'b00000, 1'b1);
    endcase
  endfunction

  task automatic set_offer(input logic v, input int idx, input logic [31:0] pc);
    instr_valid = v;
    cur_idx     = idx;
    instr_w     = instr_of(idx);
    pc_w        = pc;
  endtask

  // One clock: compare both DUTs against their models, then advance the models.
  task automatic cycle();
    bit   acc1, acc0, con1, con0;
    exp_t e;
    @(negedge clk);
    check("s1_valid", 128'(bus1.o_decode_valid), 128'(q1.size() != 0));
    check("s1_ready", 128'(bus1.o_instr_ready), 128'(q1.size() != 2));
    if (q1.size() != 0) check("s1_bundle", bnd1, q1[0]);
    check("s0_valid", 128'(bus0.o_decode_valid), 128'(q0.size() != 0));
    check("s0_ready", 128'(bus0.o_instr_ready), 128'(q0.size() == 0 || dec_ready));
    if (q0.size() != 0) check("s0_bundle", bnd0, q0[0]);
    acc1 = instr_valid && (q1.size() != 2) && !flush;
    acc0 = instr_valid && (q0.size() == 0 || dec_ready) && !flush;
    con1 = (q1.size() != 0) && dec_ready;
    con0 = (q0.size() != 0) && dec_ready;
    e    = tbl(cur_idx);
    e.pc = pc_w;
    @(posedge clk);
    if (flush) begin
      q1.delete();
      q0.delete();
    end else begin
      if (con1) void'(q1.pop_front());
      if (acc1) q1.push_back(e);
      if (con0) void'(q0.pop_front());
      if (acc0) q0.push_back(e);
    end
    last_acc1 = acc1;
    #1;
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_valid1"}, 128'(bus1.o_decode_valid), 128'(0));
    check({tag, "_ready1"}, 128'(bus1.o_instr_ready), 128'(1));
    check({tag, "_bundle1"}, bnd1, 128'(0));
    check({tag, "_valid0"}, 128'(bus0.o_decode_valid), 128'(0));
    check({tag, "_ready0"}, 128'(bus0.o_instr_ready), 128'(1));
    check({tag, "_bundle0"}, bnd0, 128'(0));
  endtask

  initial begin
    int nxt;
    #1 rstn = 1'b0;
    #1 chk_reset("rst");
    @(posedge clk);
    #3 rstn = 1'b1;

    // Single decodes with execute always ready.
    dec_ready = 1'b1;
    set_offer(1'b1, 0, 32'h100);
    cycle();
    check("addi_valid", 128'(bus1.o_decode_valid), 128'(1));
    check("addi_rd", 128'(bus1.o_rd_addr), 128'(1));
    check("addi_rs1", 128'(bus1.o_rs1_addr), 128'(2));
    check("addi_imm", 128'(bus1.o_imm), 128'(5));
    check("addi_is_imm", 128'(bus1.o_is_imm_op), 128'(1));
    check("addi_rd_wen", 128'(bus1.o_rd_wen), 128'(1));
    check("addi_pc", 128'(bus1.o_pc), 128'(32'h100));
    set_offer(1'b1, 1, 32'h104);
    cycle();
    check("sw_imm", 128'(bus1.o_imm), 128'(64'hFFFF_FFFF_FFFF_FFFC));
    check("sw_is_store", 128'(bus1.o_is_store_op), 128'(1));
    check("sw_rd_wen", 128'(bus1.o_rd_wen), 128'(0));
    set_offer(1'b1, 2, 32'h108);
    cycle();
    check("zero_illegal", 128'(bus1.o_illegal), 128'(1));
    check("zero_flags", 128'({bus1.o_is_imm_op, bus1.o_is_jump_op, bus1.o_is_branch_op,
                              bus1.o_is_load_op, bus1.o_is_store_op}), 128'(0));
    set_offer(1'b1, 3, 32'h10C);
    cycle();
    check("nop_illegal", 128'(bus1.o_illegal), 128'(0));
    check("nop_rd_wen", 128'(bus1.o_rd_wen), 128'(0));
    set_offer(1'b0, 0, 32'h0);
    cycle();
    cycle();

    // Back-pressure: four instructions, execute stalls for three cycles.
    nxt = 0;
    for (int c = 0; c < 10; c++) begin
      dec_ready = !(c >= 1 && c <= 3);
      if (nxt < 4) set_offer(1'b1, 4 + nxt, 32'h200 + 32'(nxt * 4));
      else set_offer(1'b0, 0, 32'h0);
      cycle();
      if (last_acc1) nxt++;
      if (c == 1) begin
        check("bp_ready_low", 128'(bus1.o_instr_ready), 128'(0));
        check("bp_hold_pc", 128'(bus1.o_pc), 128'(32'h200));
      end
      if (c == 3) check("bp_stable_pc", 128'(bus1.o_pc), 128'(32'h200));
    end

    // Flush while the skid entry is occupied, with a concurrent offer.
    dec_ready = 1'b0;
    set_offer(1'b1, 8, 32'h300);
    cycle();
    set_offer(1'b1, 9, 32'h304);
    cycle();
    check("pre_flush_ready", 128'(bus1.o_instr_ready), 128'(0));
    flush = 1'b1;
    set_offer(1'b1, 10, 32'h308);
    cycle();
    flush = 1'b0;
    check("flush_valid", 128'(bus1.o_decode_valid), 128'(0));
    check("flush_ready", 128'(bus1.o_instr_ready), 128'(1));
    dec_ready = 1'b1;
    set_offer(1'b1, 0, 32'h30C);
    cycle();
    check("flush_first_pc", 128'(bus1.o_pc), 128'(32'h30C));
    set_offer(1'b0, 0, 32'h0);
    cycle();
    cycle();

    // Random traffic with an asynchronous reset in the middle.
    for (int i = 0; i < 10000; i++) begin
      dec_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 99) < 3);
      set_offer($urandom_range(0, 9) < 7, int'($urandom_range(0, 10)), $urandom & 32'hFFFF_FFFC);
      cycle();
      if (i == 5000) begin
        #2 rstn = 1'b0;
        #1 chk_reset("mid_rst");
        q1.delete();
        q0.delete();
        rstn = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
